// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch stage: owns the PC, runs the imem req/ack
// handshake and presents one registered instruction to decode/control.
module wiscsc15_fetch #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       INSTR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus1,
    output logic               halted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_HALT
    } state_t;

    state_t             r_state, w_state;
    logic [ADDR_W-1:0]  r_pc, w_pc;
    logic               r_req, w_req;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic               r_valid, w_valid;
    logic [INSTR_W-1:0] r_instr, w_instr;
    logic [ADDR_W-1:0]  r_pc_out, w_pc_out;
    logic               r_kill, w_kill;
    logic               w_slot_free;
    logic               w_consume;
    logic [3:0]         w_rd_op;

    assign w_slot_free = !r_valid || !stall;
    assign w_consume   = r_valid && !stall;
    assign w_rd_op     = imem_rdata[INSTR_W-1 -: 4];

    always_comb begin
        w_state  = r_state;
        w_pc     = r_pc;
        w_req    = r_req;
        w_addr   = r_addr;
        w_valid  = r_valid;
        w_instr  = r_instr;
        w_pc_out = r_pc_out;
        w_kill   = r_kill;

        if (w_consume) begin
            w_valid = 1'b0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_pc = redirect_pc;
                end else if (w_slot_free) begin
                    w_req   = 1'b1;
                    w_addr  = r_pc;
                    w_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (imem_ack && !r_kill && !redirect) begin
                    w_instr  = imem_rdata;
                    w_pc_out = r_addr;
                    w_valid  = 1'b1;
                    w_pc     = r_pc + ADDR_W'(1);
                    w_req    = 1'b0;
                    w_state  = (w_rd_op == HALT_OPCODE) ? S_HALT : S_IDLE;
                end else if (imem_ack) begin
                    // stale access completes; its data is dropped
                    w_kill  = 1'b0;
                    w_req   = 1'b0;
                    w_state = S_IDLE;
                    if (redirect) begin
                        w_pc = redirect_pc;
                    end
                end else if (redirect) begin
                    w_pc   = redirect_pc;
                    w_kill = 1'b1;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    w_pc    = redirect_pc;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (redirect) begin
            w_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_valid  <= 1'b0;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_kill   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pc     <= w_pc;
            r_req    <= w_req;
            r_addr   <= w_addr;
            r_valid  <= w_valid;
            r_instr  <= w_instr;
            r_pc_out <= w_pc_out;
            r_kill   <= w_kill;
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_addr;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign opcode      = r_instr[INSTR_W-1 -: 4];
    assign pc_out      = r_pc_out;
    assign pc_plus1    = r_pc_out + ADDR_W'(1);
    assign halted      = (r_state == S_HALT);

endmodule
